// File: rtl/huff_decoder.sv
// Huffman stream decoder: unpacks 32-bit code words and matches one bit
// per cycle against a loadable code table to rebuild 8-bit characters.
module huff_decoder #(
    parameter int TABLE_SIZE   = 32,
    parameter int INDEX_WIDTH  = 5,
    parameter int MAX_CODE_LEN = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   tableClear,
    input  logic                   tableWrite,
    input  logic [INDEX_WIDTH-1:0] tableIndex,
    input  logic [15:0]            tableCode,
    input  logic [4:0]             tableLength,
    input  logic [7:0]             tableChar,
    input  logic                   startFrame,
    input  logic [31:0]            wordIn,
    input  logic                   wordValid,
    output logic                   wordReady,
    output logic [7:0]             charOut,
    output logic                   charValid,
    input  logic                   charReady,
    output logic                   frameDone,
    output logic                   error,
    output logic [15:0]            bitsRemaining,
    output logic [3:0]             log
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_HEADER = 4'd1,
        S_SHIFT  = 4'd2,
        S_EMIT   = 4'd3,
        S_FETCH  = 4'd4,
        S_DONE   = 4'd5,
        S_ERROR  = 4'd6
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] shift_q, shift_d;
    logic [5:0]  bin_q, bin_d;
    logic [15:0] rem_q, rem_d;
    logic [15:0] acc_q, acc_d;
    logic [4:0]  alen_q, alen_d;
    logic [7:0]  char_q, char_d;
    logic        cv_q, cv_d;
    logic        err_q, err_d;

    logic [15:0] code_q [TABLE_SIZE];
    logic [4:0]  len_q  [TABLE_SIZE];
    logic [7:0]  chr_q  [TABLE_SIZE];

    logic [15:0]            acc_sh;
    logic [4:0]             alen_sh;
    logic [15:0]            rem_sh;
    logic [5:0]             bin_sh;
    logic                   hit;
    logic [INDEX_WIDTH-1:0] hit_idx;
    logic                   tbl_open;
    logic                   tbl_we;

    assign acc_sh  = {acc_q[14:0], shift_q[31]};
    assign alen_sh = alen_q + 5'd1;
    assign rem_sh  = rem_q - 16'd1;
    assign bin_sh  = bin_q - 6'd1;

    assign tbl_open = (state_q == S_IDLE) || (state_q == S_DONE) ||
                      (state_q == S_ERROR);
    assign tbl_we   = tableWrite && tbl_open &&
                      (32'(tableIndex) < TABLE_SIZE) &&
                      (32'(tableLength) <= MAX_CODE_LEN);

    // acc holds exactly alen bits with zeros above, so a full-width compare works
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int e = TABLE_SIZE - 1; e >= 0; e--) begin
            if (len_q[e] == alen_sh && code_q[e] == acc_sh) begin
                hit     = 1'b1;
                hit_idx = INDEX_WIDTH'(e);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int e = 0; e < TABLE_SIZE; e++) begin
                code_q[e] <= '0;
                len_q[e]  <= '0;
                chr_q[e]  <= '0;
            end
        end else if (tableClear) begin
            for (int e = 0; e < TABLE_SIZE; e++) begin
                len_q[e] <= '0;
            end
        end else if (tbl_we) begin
            code_q[tableIndex] <= tableCode;
            len_q[tableIndex]  <= tableLength;
            chr_q[tableIndex]  <= tableChar;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bin_d   = bin_q;
        rem_d   = rem_q;
        acc_d   = acc_q;
        alen_d  = alen_q;
        char_d  = char_q;
        cv_d    = cv_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (startFrame) begin
                    state_d = S_HEADER;
                    acc_d   = '0;
                    alen_d  = '0;
                    err_d   = 1'b0;
                end
            end
            S_HEADER: begin
                if (wordValid) begin
                    rem_d   = wordIn[31:16];
                    shift_d = {wordIn[15:0], 16'h0};
                    bin_d   = (wordIn[31:16] >= 16'd16) ? 6'd16
                                                        : {2'b00, wordIn[19:16]};
                    state_d = (wordIn[31:16] == 16'd0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                shift_d = {shift_q[30:0], 1'b0};
                bin_d   = bin_sh;
                rem_d   = rem_sh;
                acc_d   = acc_sh;
                alen_d  = alen_sh;
                if (hit) begin
                    char_d  = chr_q[hit_idx];
                    cv_d    = 1'b1;
                    acc_d   = '0;
                    alen_d  = '0;
                    state_d = S_EMIT;
                end else if (alen_sh == 5'(MAX_CODE_LEN) || rem_sh == 16'd0) begin
                    err_d   = 1'b1;
                    state_d = S_ERROR;
                end else if (bin_sh == 6'd0) begin
                    state_d = S_FETCH;
                end
            end
            S_EMIT: begin
                if (charReady) begin
                    cv_d = 1'b0;
                    if (rem_q == 16'd0) begin
                        state_d = S_DONE;
                    end else if (bin_q == 6'd0) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_FETCH: begin
                if (wordValid) begin
                    shift_d = wordIn;
                    bin_d   = (rem_q >= 16'd32) ? 6'd32 : rem_q[5:0];
                    state_d = S_SHIFT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERROR: begin
                cv_d = 1'b0;
                if (startFrame) begin
                    state_d = S_HEADER;
                    acc_d   = '0;
                    alen_d  = '0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            bin_q   <= '0;
            rem_q   <= '0;
            acc_q   <= '0;
            alen_q  <= '0;
            char_q  <= '0;
            cv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bin_q   <= bin_d;
            rem_q   <= rem_d;
            acc_q   <= acc_d;
            alen_q  <= alen_d;
            char_q  <= char_d;
            cv_q    <= cv_d;
            err_q   <= err_d;
        end
    end

    assign wordReady     = (state_q == S_HEADER) || (state_q == S_FETCH);
    assign charOut       = char_q;
    assign charValid     = cv_q;
    assign frameDone     = (state_q == S_DONE);
    assign error         = err_q;
    assign bitsRemaining = rem_q;
    assign log           = state_q;

endmodule

// File: tb/tb_huff_decoder.sv
// Directed bench for huff_decoder: vector table of frames plus
// hand-written stall, table-clear, code-length and reset sequences.
module tb_huff_decoder;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        tableClear = 1'b0;
    logic        tableWrite = 1'b0;
    logic [4:0]  tableIndex = '0;
    logic [15:0] tableCode = '0;
    logic [4:0]  tableLength = '0;
    logic [7:0]  tableChar = '0;
    logic        startFrame = 1'b0;
    logic [31:0] wordIn = '0;
    logic        wordValid = 1'b0;
    logic        wordReady;
    logic [7:0]  charOut;
    logic        charValid;
    logic        charReady = 1'b0;
    logic        frameDone;
    logic        error;
    logic [15:0] bitsRemaining;
    logic [3:0]  log;

    int nerr = 0;
    int nchk = 0;

    huff_decoder dut (
        .clock(clock), .reset(reset),
        .tableClear(tableClear), .tableWrite(tableWrite),
        .tableIndex(tableIndex), .tableCode(tableCode),
        .tableLength(tableLength), .tableChar(tableChar),
        .startFrame(startFrame), .wordIn(wordIn),
        .wordValid(wordValid), .wordReady(wordReady),
        .charOut(charOut), .charValid(charValid),
        .charReady(charReady), .frameDone(frameDone),
        .error(error), .bitsRemaining(bitsRemaining), .log(log)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [31:0] w0;
        logic [31:0] w1;
        string       chars;
        bit          err;
        int          lat;
        int          nrdy;
    } vec_t;

    function automatic vec_t mk(input string nm, input logic [31:0] a,
                                input logic [31:0] b, input string c,
                                input bit e, input int l, input int r);
        vec_t v;
        v.name = nm; v.w0 = a; v.w1 = b; v.chars = c;
        v.err = e; v.lat = l; v.nrdy = r;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] ex);
        nchk++;
        if (act !== ex) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, ex);
        end
    endtask

    task automatic wr(input int idx, input logic [15:0] code,
                      input logic [4:0] len, input logic [7:0] ch,
                      input bit clr);
        tableWrite  = 1'b1;
        tableIndex  = 5'(idx);
        tableCode   = code;
        tableLength = len;
        tableChar   = ch;
        tableClear  = clr;
        @(negedge clock);
        tableWrite = 1'b0;
        tableClear = 1'b0;
    endtask

    // lat = negedges from the one where the header is offered to the
    // first event (char, frameDone or error)
    task automatic run_frame(input vec_t v, input int stall_at,
                             input int stall_n, input logic [7:0] s_ch,
                             input logic [15:0] s_rem);
        int  ngot = 0, nrdy = 0, xcyc = 0, lat = -1, stalls = 0;
        bit  done = 0, err = 0;
        startFrame = 1'b1;
        @(negedge clock);
        startFrame = 1'b0;
        chk({v.name, " err_clear"}, 32'(error), 32'd0);
        for (int cyc = 0; cyc < 400 && !done && !err; cyc++) begin
            wordValid = 1'b0;
            charReady = 1'b0;
            if (frameDone) begin
                done = 1;
                if (lat < 0) lat = cyc - xcyc;
            end else if (error) begin
                err = 1;
                if (lat < 0) lat = cyc - xcyc;
            end else begin
                if (wordReady) begin
                    wordValid = 1'b1;
                    wordIn    = (nrdy == 0) ? v.w0 : v.w1;
                    if (nrdy == 0) xcyc = cyc;
                    nrdy++;
                end
                if (charValid) begin
                    if (lat < 0) lat = cyc - xcyc;
                    if (ngot == stall_at && stalls < stall_n) begin
                        stalls++;
                        chk({v.name, " stall_char"}, 32'(charOut), 32'(s_ch));
                        chk({v.name, " stall_rem"}, 32'(bitsRemaining),
                            32'(s_rem));
                    end else begin
                        charReady = 1'b1;
                        if (ngot < v.chars.len())
                            chk($sformatf("%s ch%0d", v.name, ngot),
                                32'(charOut), 32'(v.chars[ngot]));
                        else
                            chk($sformatf("%s extra_ch%0d", v.name, ngot),
                                32'(charOut), 32'hFFFF_FFFF);
                        ngot++;
                    end
                end
            end
            @(negedge clock);
        end
        wordValid = 1'b0;
        charReady = 1'b0;
        chk({v.name, " finished"}, 32'(done || err), 32'd1);
        chk({v.name, " error"}, 32'(err), 32'(v.err));
        chk({v.name, " latency"}, 32'(lat), 32'(v.lat));
        chk({v.name, " word_xfers"}, 32'(nrdy), 32'(v.nrdy));
        chk({v.name, " n_chars"}, 32'(ngot), 32'(v.chars.len()));
        if (stall_n > 0)
            chk({v.name, " stall_cycles"}, 32'(stalls), 32'(stall_n));
        if (done)
            chk({v.name, " done_pulse_end"}, 32'(frameDone), 32'd0);
        if (err)
            chk({v.name, " no_char_in_error"}, 32'(charValid), 32'd0);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = mk("T1", 32'h0005_5800, 32'h0, "ABC", 0, 2, 1);
        vecs[1] = mk("T2", 32'h0014_FFFF, 32'hF000_0000, "CCCCCCCCCC",
                     0, 3, 2);
        vecs[2] = mk("T5", 32'h0000_1234, 32'h0, "", 0, 1, 1);
        vecs[3] = mk("mix", 32'h0008_C600, 32'h0, "CAAACA", 0, 3, 1);
        vecs[4] = mk("short", 32'h0001_8000, 32'h0, "", 1, 2, 1);
        vecs[5] = mk("span", 32'h0011_0001, 32'h8000_0000,
                     "AAAAAAAAAAAAAAAC", 0, 2, 2);

        #1;
        chk("rst wordReady", 32'(wordReady), 32'd0);
        chk("rst charValid", 32'(charValid), 32'd0);
        chk("rst charOut", 32'(charOut), 32'd0);
        chk("rst frameDone", 32'(frameDone), 32'd0);
        chk("rst error", 32'(error), 32'd0);
        chk("rst bitsRemaining", 32'(bitsRemaining), 32'd0);
        chk("rst log", 32'(log), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        wr(0, 16'h0000, 5'd1, 8'h41, 0);
        wr(1, 16'h0002, 5'd2, 8'h42, 0);
        wr(2, 16'h0003, 5'd2, 8'h43, 0);
        wr(5, 16'h0000, 5'd1, 8'h5A, 0);

        for (int i = 0; i < 6; i++)
            run_frame(vecs[i], -1, 0, 8'h00, 16'h0);

        run_frame(mk("T3", 32'h0005_5800, 32'h0, "ABC", 0, 2, 1),
                  1, 5, 8'h42, 16'd2);

        wr(0, 16'h0000, 5'd1, 8'h41, 1);
        wr(0, 16'h0000, 5'd1, 8'h41, 0);
        run_frame(mk("clr_wins", 32'h0002_8000, 32'h0, "", 1, 3, 1),
                  -1, 0, 8'h00, 16'h0);
        run_frame(mk("T4", 32'h0003_E000, 32'h0, "", 1, 4, 1),
                  -1, 0, 8'h00, 16'h0);
        run_frame(mk("maxlen", 32'h0020_FFFF, 32'hFFFF_FFFF, "", 1, 17, 1),
                  -1, 0, 8'h00, 16'h0);
        wr(0, 16'h0000, 5'd17, 8'h51, 0);
        run_frame(mk("len17_ignored", 32'h0001_0000, 32'h0, "A", 0, 2, 1),
                  -1, 0, 8'h00, 16'h0);

        startFrame = 1'b1;
        @(negedge clock);
        startFrame = 1'b0;
        wordValid  = 1'b1;
        wordIn     = 32'h0014_FFFF;
        @(negedge clock);
        wordValid = 1'b0;
        chk("T6 pre_state", 32'(log), 32'd2);
        chk("T6 pre_rem", 32'(bitsRemaining), 32'd20);
        reset = 1'b0;
        #1;
        chk("T6 wordReady", 32'(wordReady), 32'd0);
        chk("T6 charValid", 32'(charValid), 32'd0);
        chk("T6 charOut", 32'(charOut), 32'd0);
        chk("T6 frameDone", 32'(frameDone), 32'd0);
        chk("T6 error", 32'(error), 32'd0);
        chk("T6 bitsRemaining", 32'(bitsRemaining), 32'd0);
        chk("T6 log", 32'(log), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        run_frame(mk("T6_cleared", 32'h0001_0000, 32'h0, "", 1, 2, 1),
                  -1, 0, 8'h00, 16'h0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
